// File: rtl/pwm_cfg_sequencer_if.sv
// AXI4-Lite write-only channel bundle between the config sequencer and the PWM core S00_AXI port.
interface pwm_cfg_sequencer_if;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Round-robin arbiter for two register-write requesters, issuing single-beat AXI4-Lite
// writes to the PWM core with BRESP checking, sticky error and bus-timeout status.
module pwm_cfg_sequencer #(
    parameter logic [31:0] C_BASE_ADDR = 32'h44A0_0000,
    parameter logic [7:0]  C_TIMEOUT   = 8'd255
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        req0_valid,
    input  logic [1:0]  req0_idx,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_idx,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    pwm_cfg_sequencer_if.master axi,
    output logic        busy,
    output logic        done,
    output logic [1:0]  last_resp,
    output logic        err,
    output logic        timeout,
    input  logic        err_clr
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t      state, state_nxt;
    logic        rr_ptr;
    logic [7:0]  tmo_cnt;
    logic        grant0, grant1, aw_ok, w_ok, b_hs, tmo_hit, abort;
    logic [1:0]  sel_idx;
    logic [31:0] sel_data;
    logic [31:0] awaddr_q, wdata_q;
    logic        awvalid_q, wvalid_q, bready_q;

    assign axi.m_axi_awaddr  = awaddr_q;
    assign axi.m_axi_awprot  = 3'b000;
    assign axi.m_axi_awvalid = awvalid_q;
    assign axi.m_axi_wdata   = wdata_q;
    assign axi.m_axi_wstrb   = 4'hF;
    assign axi.m_axi_wvalid  = wvalid_q;
    assign axi.m_axi_bready  = bready_q;

    assign busy       = (state != IDLE);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        abort     = 1'b0;
        sel_idx   = req0_idx;
        sel_data  = req0_data;
        // A channel counts as complete once its valid has dropped or it handshakes now.
        aw_ok     = ~awvalid_q | axi.m_axi_awready;
        w_ok      = ~wvalid_q | axi.m_axi_wready;
        b_hs      = (state == RESP) & axi.m_axi_bvalid;
        tmo_hit   = (tmo_cnt == C_TIMEOUT - 8'd1);
        case (state)
            IDLE: begin
                // Holding off grants during the done cycle keeps grants 4 cycles apart.
                if (!done) begin
                    if (req0_valid && (!req1_valid || !rr_ptr)) grant0 = 1'b1;
                    else if (req1_valid)                        grant1 = 1'b1;
                end
                if (grant1) begin
                    sel_idx  = req1_idx;
                    sel_data = req1_data;
                end
                if (grant0 || grant1) state_nxt = XFER;
            end
            XFER: begin
                if (aw_ok && w_ok) state_nxt = RESP;
                else if (tmo_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                if (b_hs) state_nxt = IDLE;
                else if (tmo_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rr_ptr    <= 1'b0;
            tmo_cnt   <= 8'd0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done      <= 1'b0;
            last_resp <= 2'b00;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tmo_cnt <= (state_nxt != state || state == IDLE) ? 8'd0 : tmo_cnt + 8'd1;
            if (grant0 || grant1) begin
                awaddr_q  <= C_BASE_ADDR + {28'd0, sel_idx, 2'b00};
                wdata_q   <= sel_data;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                if (req0_valid && req1_valid) rr_ptr <= grant0;
            end else begin
                if (abort || axi.m_axi_awready) awvalid_q <= 1'b0;
                if (abort || axi.m_axi_wready)  wvalid_q  <= 1'b0;
            end
            bready_q <= (state_nxt == RESP);
            done     <= b_hs | abort;
            if (b_hs) last_resp <= axi.m_axi_bresp;
            // Sticky flags: a set in the same cycle as err_clr wins.
            err     <= (b_hs && axi.m_axi_bresp != 2'b00) | (err & ~err_clr);
            timeout <= abort | (timeout & ~err_clr);
        end
    end
endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Bench for pwm_cfg_sequencer: reactive AXI slave with a write scoreboard fed by observed grants.
module tb_pwm_cfg_sequencer;
    localparam logic [31:0] BASE = 32'h44A0_0000;
    localparam int          TMO  = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]  req0_idx, req1_idx;
    logic [31:0] req0_data, req1_data;
    logic        busy, done, err, timeout, err_clr;
    logic [1:0]  last_resp;

    pwm_cfg_sequencer_if axi();

    pwm_cfg_sequencer dut (
        .ACLK(clk), .ARESETN(rst_n),
        .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_data(req1_data), .req1_ready(req1_ready),
        .axi(axi),
        .busy(busy), .done(done), .last_resp(last_resp), .err(err), .timeout(timeout),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        sb[$];
    int          gq[$];
    int          gcyc[$];
    logic [31:0] mem [4];
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic [1:0]  bresp_val = 2'b00;
    bit          b_never = 1'b0;
    int          aw_hs_cyc = 0;
    int          w_hs_cyc  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Grant monitor: every observed grant pushes the write the slave must later see.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (req0_ready || req1_ready)) begin
                total++;
                if ({req0_ready & req1_ready, busy} !== 2'b00) begin
                    bad++;
                    $display("FAIL grant_excl: r0=%b r1=%b busy=%b want single grant in IDLE",
                             req0_ready, req1_ready, busy);
                end
                if (req0_ready) begin
                    e.addr = BASE + {28'd0, req0_idx, 2'b00};
                    e.data = req0_data;
                    sb.push_back(e);
                    gq.push_back(0);
                    gcyc.push_back(cyc);
                end else begin
                    e.addr = BASE + {28'd0, req1_idx, 2'b00};
                    e.data = req1_data;
                    sb.push_back(e);
                    gq.push_back(1);
                    gcyc.push_back(cyc);
                end
            end
        end
    end

    // Slave model: acts #1 after each rising edge; p_* hold what was on the bus at that edge.
    initial begin
        logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
        logic aw_got, w_got, b_pend, both_now;
        logic [31:0] p_awaddr, p_wdata, cap_addr, cap_data;
        logic [3:0]  p_wstrb;
        logic [2:0]  p_awprot;
        int aw_wait, w_wait;
        exp_t e;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
        aw_got = 0; w_got = 0; b_pend = 0; both_now = 0;
        p_awaddr = 0; p_wdata = 0; cap_addr = 0; cap_data = 0; p_wstrb = 0; p_awprot = 0;
        aw_wait = 0; w_wait = 0;
        axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_bvalid = 0; axi.m_axi_bresp = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; b_pend = 0; aw_wait = 0; w_wait = 0;
                axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_bvalid = 0;
            end else begin
                both_now = 0;
                if (p_awv && p_awr) begin
                    aw_got = 1; cap_addr = p_awaddr; aw_hs_cyc = cyc;
                    total++;
                    if ({axi.m_axi_awvalid, p_awprot} !== 4'b0000) begin
                        bad++;
                        $display("FAIL aw_after_hs: awvalid=%b awprot=%h want 0/0",
                                 axi.m_axi_awvalid, p_awprot);
                    end
                end else if (p_awv) begin
                    total++;
                    if ({axi.m_axi_awvalid, axi.m_axi_awaddr} !== {1'b1, p_awaddr}) begin
                        bad++;
                        $display("FAIL aw_hold: awvalid=%b awaddr=%h want 1/%h",
                                 axi.m_axi_awvalid, axi.m_axi_awaddr, p_awaddr);
                    end
                end
                if (p_wv && p_wr) begin
                    w_got = 1; cap_data = p_wdata; w_hs_cyc = cyc;
                    total++;
                    if ({axi.m_axi_wvalid, p_wstrb} !== 5'b0_1111) begin
                        bad++;
                        $display("FAIL w_after_hs: wvalid=%b wstrb=%h want 0/f",
                                 axi.m_axi_wvalid, p_wstrb);
                    end
                end else if (p_wv) begin
                    total++;
                    if ({axi.m_axi_wvalid, axi.m_axi_wdata} !== {1'b1, p_wdata}) begin
                        bad++;
                        $display("FAIL w_hold: wvalid=%b wdata=%h want 1/%h",
                                 axi.m_axi_wvalid, axi.m_axi_wdata, p_wdata);
                    end
                end
                if (p_bv && p_br)                     b_pend = 0;
                else if (p_br && !axi.m_axi_bready)   b_pend = 0;
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0; b_pend = 1; both_now = 1;
                    mem[cap_addr[3:2]] = cap_data;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_write: got addr=%h data=%h want no write", cap_addr, cap_data);
                    end else begin
                        e = sb.pop_front();
                        if ({cap_addr, cap_data} !== {e.addr, e.data}) begin
                            bad++;
                            $display("FAIL sb_write: got addr=%h data=%h want addr=%h data=%h",
                                     cap_addr, cap_data, e.addr, e.data);
                        end
                    end
                end
                if (axi.m_axi_bready && !p_br) begin
                    total++;
                    if (both_now !== 1'b1) begin
                        bad++;
                        $display("FAIL resp_entry: bready rose with both_hs_prev=%b want 1", both_now);
                    end
                end
                axi.m_axi_awready = axi.m_axi_awvalid && (aw_wait >= aw_delay);
                if (axi.m_axi_awready)        aw_wait = 0;
                else if (axi.m_axi_awvalid)   aw_wait++;
                axi.m_axi_wready = axi.m_axi_wvalid && (w_wait >= w_delay);
                if (axi.m_axi_wready)         w_wait = 0;
                else if (axi.m_axi_wvalid)    w_wait++;
                axi.m_axi_bvalid = b_pend && !b_never;
                axi.m_axi_bresp  = bresp_val;
            end
            p_awv = rst_n && axi.m_axi_awvalid; p_awr = axi.m_axi_awready;
            p_wv  = rst_n && axi.m_axi_wvalid;  p_wr  = axi.m_axi_wready;
            p_bv  = axi.m_axi_bvalid;           p_br  = rst_n && axi.m_axi_bready;
            p_awaddr = axi.m_axi_awaddr; p_awprot = axi.m_axi_awprot;
            p_wdata  = axi.m_axi_wdata;  p_wstrb  = axi.m_axi_wstrb;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_write(input int id, input logic [1:0] idx, input logic [31:0] data, output int g);
        @(posedge clk); #2;
        if (id == 0) begin req0_valid = 1; req0_idx = idx; req0_data = data; end
        else         begin req1_valid = 1; req1_idx = idx; req1_data = data; end
        g = -1;
        for (int k = 0; k < 50 && g < 0; k++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) g = cyc;
        end
        @(posedge clk); #2;
        // Scramble inputs after the grant; the in-flight write must not follow them.
        if (id == 0) begin req0_valid = 0; req0_idx = idx + 2'd1; req0_data = ~data; end
        else         begin req1_valid = 0; req1_idx = idx + 2'd1; req1_data = ~data; end
        if (g < 0) begin
            total++; bad++;
            $display("FAIL grant_wait: requester %0d got no grant within 50 cycles", id);
        end
    endtask

    task automatic wait_done(input int bound, output int dc);
        dc = -1;
        for (int k = 0; k < bound && dc < 0; k++) begin
            @(negedge clk);
            if (done) dc = cyc;
        end
        if (dc < 0) begin
            total++; bad++;
            $display("FAIL done_wait: no done within %0d cycles", bound);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2; err_clr = 1;
        @(posedge clk); #2; err_clr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; err_clr = 0;
        req0_valid = 0; req0_idx = 0; req0_data = 0;
        req1_valid = 0; req1_idx = 0; req1_data = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, busy, done, last_resp, err, timeout,
             req0_ready, req1_ready} !== 11'd0) begin
            bad++;
            $display("FAIL reset_ctl: aw=%b w=%b b=%b busy=%b done=%b lr=%h err=%b to=%b want all 0",
                     axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, busy, done, last_resp, err, timeout);
        end
        total++;
        if ({axi.m_axi_awaddr, axi.m_axi_wdata} !== 64'd0) begin
            bad++;
            $display("FAIL reset_data: awaddr=%h wdata=%h want 0/0", axi.m_axi_awaddr, axi.m_axi_wdata);
        end
        @(posedge clk); #2; rst_n = 1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        int g, dc;
        do_write(0, 2'd2, 32'hDEAD0011, g);
        wait_done(20, dc);
        total++;
        if (dc - g !== 3) begin
            bad++;
            $display("FAIL single_lat: done at grant+%0d want grant+3", dc - g);
        end
        total++;
        if ({last_resp, err, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL single_stat: last_resp=%h err=%b busy=%b want 0/0/0", last_resp, err, busy);
        end
        total++;
        if (mem[2] !== 32'hDEAD0011) begin
            bad++;
            $display("FAIL single_readback: reg2=%h want DEAD0011", mem[2]);
        end
    endtask

    task automatic test_contention();
        int base, dc;
        base = gq.size();
        @(posedge clk); #2;
        req0_valid = 1; req0_idx = 2'd1; req0_data = 32'hA000_0001;
        req1_valid = 1; req1_idx = 2'd3; req1_data = 32'hB000_0003;
        for (int k = 0; k < 200 && gq.size() - base < 8; k++) begin
            @(posedge clk); #2;
        end
        req0_valid = 0; req1_valid = 0;
        wait_done(20, dc);
        total++;
        if (gq.size() - base !== 8) begin
            bad++;
            $display("FAIL cont_count: grants=%0d want 8", gq.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (gq[base + i] !== i % 2) begin
                    bad++;
                    $display("FAIL cont_order: grant %0d to req%0d want req%0d", i, gq[base + i], i % 2);
                end
            end
            for (int i = 1; i < 8; i++) begin
                total++;
                if (gcyc[base + i] - gcyc[base + i - 1] !== 4) begin
                    bad++;
                    $display("FAIL cont_spacing: gap %0d want 4", gcyc[base + i] - gcyc[base + i - 1]);
                end
            end
        end
    endtask

    task automatic test_handshake_order();
        int g, dc;
        w_delay = 3; aw_delay = 5;
        do_write(1, 2'd0, 32'h0BAD_F00D, g);
        wait_done(40, dc);
        total++;
        if (aw_hs_cyc - w_hs_cyc !== 2) begin
            bad++;
            $display("FAIL hs_order: aw-w handshake gap %0d want 2", aw_hs_cyc - w_hs_cyc);
        end
        total++;
        if (dc - g !== 8) begin
            bad++;
            $display("FAIL hs_latency: done at grant+%0d want grant+8", dc - g);
        end
        w_delay = 0; aw_delay = 0;
    endtask

    task automatic test_error();
        int g, dc;
        bresp_val = 2'b10;
        do_write(1, 2'd1, 32'h1111_2222, g);
        wait_done(20, dc);
        total++;
        if ({err, last_resp} !== 3'b1_10) begin
            bad++;
            $display("FAIL err_set: err=%b last_resp=%h want 1/2", err, last_resp);
        end
        bresp_val = 2'b00;
        do_write(0, 2'd3, 32'h3333_4444, g);
        wait_done(20, dc);
        total++;
        if ({err, last_resp} !== 3'b1_00) begin
            bad++;
            $display("FAIL err_sticky: err=%b last_resp=%h want 1/0", err, last_resp);
        end
        pulse_clr();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: err=%b want 0", err);
        end
        bresp_val = 2'b10;
        do_write(0, 2'd0, 32'h5555_6666, g);
        @(posedge clk); #2; err_clr = 1;
        @(posedge clk); #2; err_clr = 0;
        @(negedge clk);
        total++;
        if ({done, err} !== 2'b11) begin
            bad++;
            $display("FAIL err_set_wins: done=%b err=%b want 1/1", done, err);
        end
        bresp_val = 2'b00;
        pulse_clr();
    endtask

    task automatic test_timeout();
        int g, dc;
        b_never = 1;
        do_write(0, 2'd1, 32'h7777_8888, g);
        wait_done(400, dc);
        total++;
        if (dc - g !== 2 + TMO) begin
            bad++;
            $display("FAIL tmo_latency: done at grant+%0d want grant+%0d", dc - g, 2 + TMO);
        end
        total++;
        if ({timeout, err, busy, axi.m_axi_bready} !== 4'b1000) begin
            bad++;
            $display("FAIL tmo_flags: timeout=%b err=%b busy=%b bready=%b want 1/0/0/0",
                     timeout, err, busy, axi.m_axi_bready);
        end
        b_never = 0;
        do_write(1, 2'd2, 32'h9999_AAAA, g);
        wait_done(20, dc);
        total++;
        if ({dc - g, timeout} !== {32'd3, 1'b1}) begin
            bad++;
            $display("FAIL tmo_next: done at grant+%0d timeout=%b want grant+3/1", dc - g, timeout);
        end
        pulse_clr();
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_clear: timeout=%b want 0", timeout);
        end
    endtask

    task automatic test_reset_xfer();
        int g, dc;
        aw_delay = 10;
        do_write(0, 2'd2, 32'h1234_5678, g);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: busy=%b want 1", busy);
        end
        rst_n = 0;
        #1;
        total++;
        if ({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, busy, done} !== 5'b00000) begin
            bad++;
            $display("FAIL rst_xfer: aw=%b w=%b b=%b busy=%b done=%b want all 0",
                     axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, busy, done);
        end
        repeat (3) @(posedge clk);
        #2;
        sb.delete();
        aw_delay = 0;
        rst_n = 1;
        do_write(1, 2'd3, 32'hCAFE_0003, g);
        wait_done(20, dc);
        total++;
        if (dc - g !== 3) begin
            bad++;
            $display("FAIL rst_after: done at grant+%0d want grant+3", dc - g);
        end
        total++;
        if (mem[3] !== 32'hCAFE_0003) begin
            bad++;
            $display("FAIL rst_readback: reg3=%h want CAFE0003", mem[3]);
        end
    endtask

    initial begin
        err_clr = 0;
        test_reset();
        test_single();
        test_contention();
        test_handshake_order();
        test_error();
        test_timeout();
        test_reset_xfer();
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d writes never seen want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
